matrix_alu_seq: RTL and testbench
=================================

# matrix_alu_seq

Parametrised, sequential successor to the matrix processor's 5x5 combinational ALU. It operates on N x N matrices of signed W-bit elements and registers its operands and result. It adds a start/busy/done handshake, a fixed-latency multi-cycle matrix multiply, a separate scalar operand, selectable wrap/saturate arithmetic, and overflow/error flags. It sits between the instruction decoder/register file and the result write-back path.

## Interface
- N, 5, matrix dimension (N x N elements), N >= 2
- W, 8, element width in bits, signed two's complement, W >= 4
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op_code  in  4  0 ADD, 1 SUB, 2 MUL, 3 MULS, 4 OPP, 5 TRS, 6-15 invalid
- saturate  in  1  1 = clamp results, 0 = wrap to low W bits; latched with start
- matrix_a  in  N*N*W  operand A; element (i,j) at bits [(i*N+j)*W +: W]
- matrix_b  in  N*N*W  operand B, same packing
- scalar  in  W  scalar operand for MULS
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, high exactly while state == DONE
- matrix_c  out  N*N*W  result, registered, same packing; holds until next completion
- overflow  out  1  at least one element of the last result was out of range; valid with done, held
- error  out  1  last op_code was invalid; valid with done, held

## Operation
- States: IDLE, EXEC, MUL_RUN, DONE.
- IDLE: start=1 latches op_code, saturate, matrix_a, matrix_b, scalar. The next state is MUL_RUN for op 2 (element index k cleared to 0) and EXEC for all other codes.
- EXEC: computes all N*N elements in parallel and writes matrix_c, overflow and error, then goes to DONE.
- MUL_RUN: each cycle computes c(i,j) = sum over m of a(i,m)*b(m,j), with i = k / N and j = k % N, into an internal result buffer.
  - Accumulator width is 2W + clog2(N); the sum is exact before the range check.
  - When k = N*N-1, the buffer, including the final element, is copied to matrix_c and the state goes to DONE.
  - Otherwise k increments.
- DONE: done=1 for one cycle, then IDLE. start is ignored in DONE.
- Per-element operations:
  - ADD a+b and SUB a-b, both exact in W+1 bits.
  - MULS a*scalar, exact in 2W bits.
  - OPP -a, exact in W+1 bits.
  - TRS c(i,j) = a(j,i); never overflows.
- Range rule: an exact result r is in range when -2^(W-1) <= r <= 2^(W-1)-1.
  - Out-of-range results set overflow, whatever saturate is.
  - saturate=1: the result clamps to the nearest bound.
  - saturate=0: the result is the low W bits of r.
- Invalid op_code: matrix_c = 0, overflow = 0, error = 1; done still pulses.
- error = 0 for all valid ops.
- start while busy is ignored; no queueing.
- Input changes after acceptance do not affect the in-flight operation.

## Timing
- Reset (synchronous, active-high) has priority over everything.
  - It forces IDLE, busy=0, done=0, matrix_c=0, overflow=0, error=0, k=0.
  - It aborts any in-flight operation; no done pulse follows.
- Let edge t be the edge at which start is accepted.
- Non-MUL ops: matrix_c and flags are updated at edge t+1; done=1 from edge t+1 to edge t+2.
- MUL: elements are computed at edges t+1 .. t+N*N. matrix_c and flags are updated at edge t+N*N, and done=1 from edge t+N*N to edge t+N*N+1. For N=5 that is 25 cycles.
- busy rises at edge t and falls at the edge where done falls.
- The earliest back-to-back start is the cycle after done; it is accepted at the edge that ends done+1, i.e. while IDLE.
- matrix_c never shows partial MUL results.

## Test plan
- Reset mid-MUL: assert reset at edge t+10 -> next cycle busy=0, done=0, matrix_c=0, flags 0; no later done pulse.
- ADD, N=5 W=8, all a=100, all b=50:
  - saturate=1 -> every element 127 (0x7F), overflow=1, done at t+1.
  - saturate=0 -> every element -106 (0x96), overflow=1.
- MUL with A = identity, B(i,j) = i*5+j -> matrix_c = B, overflow=0, error=0. done high exactly one cycle starting edge t+25, busy high for 26 cycles.
- OPP with a(0,0) = -128, other elements 3:
  - saturate=1 -> c(0,0)=127, others -3, overflow=1.
  - saturate=0 -> c(0,0) = -128.
- TRS with a(i,j) = i*5+j -> c(i,j) = j*5+i. Then op_code=9 -> matrix_c=0, error=1, done pulses at t+1.
- Second start pulsed during MUL_RUN -> ignored: exactly one done pulse, result from the first operands. A start one cycle after done is accepted.

Source files
------------

// File: rtl/matrix_alu_seq.sv
// Sequential N x N signed matrix ALU: registered operands and result,
// start/busy/done handshake and a one-element-per-cycle matrix multiply.
module matrix_alu_seq #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       op_code_i,
  input  logic             saturate_i,
  input  logic [N*N*W-1:0] matrix_a_i,
  input  logic [N*N*W-1:0] matrix_b_i,
  input  logic [W-1:0]     scalar_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [N*N*W-1:0] matrix_c_o,
  output logic             overflow_o,
  output logic             error_o
);

  localparam int NE = N * N;
  localparam int AW = 2 * W + $clog2(N);
  localparam int KW = $clog2(NE);
  localparam logic [KW-1:0] KLAST = KW'(NE - 1);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_MULS = 4'd3;
  localparam logic [3:0] OP_OPP  = 4'd4;
  localparam logic [3:0] OP_TRS  = 4'd5;

  typedef enum logic [1:0] {
    IDLE, EXEC, MUL_RUN, DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       op_q;
  logic             sat_q;
  logic [NE*W-1:0]  a_q, b_q;
  logic [W-1:0]     s_q;
  logic [KW-1:0]    k_q;
  logic [NE*W-1:0]  buf_q, c_q;
  logic             ovf_q, err_q, mov_q;

  logic [NE*W-1:0]  ex_c, mul_buf;
  logic             ex_ovf, ex_err;
  logic [W:0]       mres;

  // {out_of_range, result}: the flag is raised whether or not we clamp
  function automatic logic [W:0] fit(
    input logic signed [AW-1:0] r,
    input logic                 sat
  );
    logic hi, lo;
    hi = (r > MAXV);
    lo = (r < MINV);
    if (sat && hi)      fit = {1'b1, MAXV[W-1:0]};
    else if (sat && lo) fit = {1'b1, MINV[W-1:0]};
    else                fit = {hi | lo, r[W-1:0]};
  endfunction

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i)
          state_d = (op_code_i == OP_MUL) ? MUL_RUN : EXEC;
      end
      EXEC:    state_d = DONE;
      MUL_RUN: if (k_q == KLAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
  end

  always_comb begin
    logic signed [W-1:0]  ae, be, at, sv;
    logic signed [AW-1:0] r;
    logic [W:0]           res;
    ex_c   = '0;
    ex_ovf = 1'b0;
    ex_err = (op_q > OP_TRS);
    sv     = s_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ae = a_q[(i*N+j)*W +: W];
        be = b_q[(i*N+j)*W +: W];
        at = a_q[(j*N+i)*W +: W];
        r  = '0;
        unique case (1'b1)
          (op_q == OP_ADD):  r = ae + be;
          (op_q == OP_SUB):  r = ae - be;
          (op_q == OP_MULS): r = ae * sv;
          (op_q == OP_OPP):  r = -ae;
          (op_q == OP_TRS):  r = at;
          default:           r = '0;
        endcase
        res = fit(r, sat_q);
        ex_c[(i*N+j)*W +: W] = res[W-1:0];
        ex_ovf = ex_ovf | res[W];
      end
    end
    if (ex_err) begin
      ex_c   = '0;
      ex_ovf = 1'b0;
    end
  end

  // one dot product per cycle for element k = (k/N, k%N)
  always_comb begin
    int ki, kj;
    logic signed [AW-1:0] acc;
    ki  = int'(k_q) / N;
    kj  = int'(k_q) % N;
    acc = '0;
    for (int m = 0; m < N; m++)
      acc = acc + $signed(a_q[(ki*N+m)*W +: W])
                * $signed(b_q[(m*N+kj)*W +: W]);
    mres    = fit(acc, sat_q);
    mul_buf = buf_q;
    mul_buf[int'(k_q)*W +: W] = mres[W-1:0];
  end

  always_ff @(posedge clock_i) begin
    if (state_q == IDLE && start_i && !reset_i) begin
      op_q  <= op_code_i;
      sat_q <= saturate_i;
      a_q   <= matrix_a_i;
      b_q   <= matrix_b_i;
      s_q   <= scalar_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      k_q   <= '0;
      buf_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      mov_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            k_q   <= '0;
            mov_q <= 1'b0;
          end
        end
        EXEC: begin
          c_q   <= ex_c;
          ovf_q <= ex_ovf;
          err_q <= ex_err;
        end
        MUL_RUN: begin
          buf_q <= mul_buf;
          mov_q <= mov_q | mres[W];
          if (k_q == KLAST) begin
            c_q   <= mul_buf;
            ovf_q <= mov_q | mres[W];
            err_q <= 1'b0;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign matrix_c_o = c_q;
  assign overflow_o = ovf_q;
  assign error_o    = err_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Scoreboard bench for matrix_alu_seq: directed vectors, expected results
// queued at issue time and checked by a monitor on every done pulse.
module tb_matrix_alu_seq;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int NW = N * N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    op = '0;
  logic          sat = 1'b0;
  logic [NW-1:0] ma = '0, mb = '0;
  logic [W-1:0]  sc = '0;
  logic          busy, done, ovf, err;
  logic [NW-1:0] mc;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  typedef struct {
    string         nm;
    logic [NW-1:0] c;
    logic          o;
    logic          e;
    int            at;
  } exp_t;

  exp_t q[$];

  matrix_alu_seq #(.N(N), .W(W)) dut (
    .clock_i   (clk),
    .reset_i   (rst),
    .start_i   (start),
    .op_code_i (op),
    .saturate_i(sat),
    .matrix_a_i(ma),
    .matrix_b_i(mb),
    .scalar_i  (sc),
    .busy_o    (busy),
    .done_o    (done),
    .matrix_c_o(mc),
    .overflow_o(ovf),
    .error_o   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [NW-1:0] act, logic [NW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [NW-1:0] fill(logic [W-1:0] v);
    logic [NW-1:0] m;
    for (int e = 0; e < N*N; e++) m[e*W +: W] = v;
    return m;
  endfunction

  function automatic logic [NW-1:0] idx(bit tr);
    logic [NW-1:0] m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[(i*N+j)*W +: W] = W'(tr ? j*N+i : i*N+j);
    return m;
  endfunction

  function automatic logic [NW-1:0] ident();
    logic [NW-1:0] m;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[(i*N+j)*W +: W] = (i == j) ? W'(1) : W'(0);
    return m;
  endfunction

  function automatic logic [NW-1:0] corner(logic [W-1:0] c00,
                                           logic [W-1:0] oth);
    logic [NW-1:0] m;
    m = fill(oth);
    m[W-1:0] = c00;
    return m;
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (!rst && done) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL spurious_done: got done at cycle %0d required none",
                 cyc);
      end else begin
        x = q.pop_front();
        chk({x.nm, "_c"}, mc, x.c);
        chk({x.nm, "_ovf"}, NW'(ovf), NW'(x.o));
        chk({x.nm, "_err"}, NW'(err), NW'(x.e));
        chk({x.nm, "_done_cyc"}, NW'(cyc), NW'(x.at));
      end
    end
  end

  // called on a negedge with the DUT idle; returns on the negedge busy drops
  task automatic run_op(string nm, logic [3:0] o, logic s,
                        logic [NW-1:0] a, logic [NW-1:0] b,
                        logic [W-1:0] k, logic [NW-1:0] ec,
                        logic eo, logic ee, int lat, int ebusy);
    exp_t x;
    int   bc;
    op = o; sat = s; ma = a; mb = b; sc = k;
    start = 1'b1;
    x.nm = nm; x.c = ec; x.o = eo; x.e = ee; x.at = cyc + 1 + lat;
    q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    ma = '0; mb = '0; op = 4'd1;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, NW'(bc), NW'(ebusy));
  endtask

  initial begin
    exp_t x;
    int   bc;
    repeat (2) @(negedge clk);
    chk("rst_busy", NW'(busy), NW'(0));
    chk("rst_done", NW'(done), NW'(0));
    chk("rst_c", mc, '0);
    chk("rst_flags", NW'({ovf, err}), NW'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op("add_sat", 4'd0, 1'b1, fill(8'd100), fill(8'd50), '0,
           fill(8'h7F), 1'b1, 1'b0, 1, 2);

    // multiply aborted by reset at edge t+10
    op = 4'd2; sat = 1'b0; ma = ident(); mb = idx(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", NW'(busy), NW'(0));
    chk("midrst_done", NW'(done), NW'(0));
    chk("midrst_c", mc, '0);
    chk("midrst_flags", NW'({ovf, err}), NW'(0));
    rst = 1'b0;
    repeat (30) @(negedge clk);

    run_op("add_wrap", 4'd0, 1'b0, fill(8'd100), fill(8'd50), '0,
           fill(8'h96), 1'b1, 1'b0, 1, 2);
    run_op("sub_sat", 4'd1, 1'b1, fill(8'h9C), fill(8'd50), '0,
           fill(8'h80), 1'b1, 1'b0, 1, 2);
    run_op("muls_sat", 4'd3, 1'b1, fill(8'd20), '0, 8'd7,
           fill(8'h7F), 1'b1, 1'b0, 1, 2);
    run_op("mul_ident", 4'd2, 1'b1, ident(), idx(1'b0), '0,
           idx(1'b0), 1'b0, 1'b0, 25, 26);
    run_op("mul_wrap", 4'd2, 1'b0, fill(8'd10), fill(8'd10), '0,
           fill(8'hF4), 1'b1, 1'b0, 25, 26);
    run_op("opp_sat", 4'd4, 1'b1, corner(8'h80, 8'd3), '0, '0,
           corner(8'h7F, 8'hFD), 1'b1, 1'b0, 1, 2);
    run_op("opp_wrap", 4'd4, 1'b0, corner(8'h80, 8'd3), '0, '0,
           corner(8'h80, 8'hFD), 1'b1, 1'b0, 1, 2);
    run_op("trs", 4'd5, 1'b0, idx(1'b0), '0, '0,
           idx(1'b1), 1'b0, 1'b0, 1, 2);
    run_op("bad_op", 4'd9, 1'b1, fill(8'd100), fill(8'd50), '0,
           '0, 1'b0, 1'b1, 1, 2);

    // second start during MUL_RUN must be dropped
    op = 4'd2; sat = 1'b1; ma = ident(); mb = idx(1'b0);
    start = 1'b1;
    x.nm = "mul_busy_start"; x.c = idx(1'b0); x.o = 1'b0; x.e = 1'b0;
    x.at = cyc + 26;
    q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    op = 4'd0; ma = fill(8'd1); mb = fill(8'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    chk("mul_busy_start_end", NW'(bc), NW'(20));

    run_op("add_b2b", 4'd0, 1'b0, fill(8'd1), fill(8'd2), '0,
           fill(8'd3), 1'b0, 1'b0, 1, 2);

    repeat (5) @(negedge clk);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL pending_results: got %0d left required 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
